// File: rtl/byte_demux8.sv
// Byte demultiplexer/assembler: steers a stream of WIDTH-bit items into eight
// slots (addressed or sequential) and presents the assembled word until acked.
module byte_demux8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   In,
  input  logic               InValid,
  output logic               InReady,
  input  logic [2:0]         Sel,
  input  logic               Mode,
  input  logic               Clear,
  output logic [WIDTH-1:0]   Out0,
  output logic [WIDTH-1:0]   Out1,
  output logic [WIDTH-1:0]   Out2,
  output logic [WIDTH-1:0]   Out3,
  output logic [WIDTH-1:0]   Out4,
  output logic [WIDTH-1:0]   Out5,
  output logic [WIDTH-1:0]   Out6,
  output logic [WIDTH-1:0]   Out7,
  output logic [8*WIDTH-1:0] Word,
  output logic [7:0]         SlotValid,
  output logic               WordValid,
  input  logic               WordAck,
  output logic               Overwrite,
  output logic               dbg_state,
  output logic [2:0]         dbg_ptr
);

  // Handshake: an item transfers at a rising edge when InValid && InReady,
  // unless Clear is high that cycle; InReady never depends on InValid.
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 ptr_q, ptr_d;
  logic [7:0]                 slot_valid_q, slot_valid_d;
  logic [7:0][WIDTH-1:0]      out_q, out_d;
  logic                       overwrite_q, overwrite_d;
  logic [2:0]                 tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= COLLECT;
      ptr_q        <= 3'd0;
      slot_valid_q <= 8'd0;
      out_q        <= '0;
      overwrite_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      slot_valid_q <= slot_valid_d;
      out_q        <= out_d;
      overwrite_q  <= overwrite_d;
    end
  end

  assign tgt = Mode ? ptr_q : Sel;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    slot_valid_d = slot_valid_q;
    out_d        = out_q;
    overwrite_d  = 1'b0;
    if (Clear) begin
      // Clear beats both a pending write and an ack; slot data is kept.
      state_d      = COLLECT;
      ptr_d        = 3'd0;
      slot_valid_d = 8'd0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (InValid) begin
            out_d[tgt]        = In;
            slot_valid_d[tgt] = 1'b1;
            overwrite_d       = slot_valid_q[tgt];
            if (Mode) ptr_d = 3'(ptr_q + 3'd1);
            if (slot_valid_d == 8'hFF) state_d = FULL;
          end
        end
        FULL: begin
          if (WordAck) begin
            state_d      = COLLECT;
            ptr_d        = 3'd0;
            slot_valid_d = 8'd0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  assign InReady   = (state_q == COLLECT);
  assign WordValid = (state_q == FULL);
  assign SlotValid = slot_valid_q;
  assign Overwrite = overwrite_q;
  assign Word      = out_q;
  assign Out0      = out_q[0];
  assign Out1      = out_q[1];
  assign Out2      = out_q[2];
  assign Out3      = out_q[3];
  assign Out4      = out_q[4];
  assign Out5      = out_q[5];
  assign Out6      = out_q[6];
  assign Out7      = out_q[7];
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_byte_demux8.sv
// Bench for byte_demux8: directed scenarios followed by random traffic, all
// checked against a slot-array reference model of the assembler.
module tb_byte_demux8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_d;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic        mode;
  logic        clear;
  logic [7:0]  out0, out1, out2, out3, out4, out5, out6, out7;
  logic [63:0] word;
  logic [7:0]  slot_valid;
  logic        word_valid;
  logic        word_ack;
  logic        overwrite;
  logic        dbg_state;
  logic [2:0]  dbg_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] m_out [8];
  bit         m_sv  [8];
  int         m_ptr;
  bit         m_full;
  bit         m_ow;

  always #5 clk = ~clk;

  byte_demux8 #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .In(in_d), .InValid(in_valid), .InReady(in_ready),
    .Sel(sel), .Mode(mode), .Clear(clear),
    .Out0(out0), .Out1(out1), .Out2(out2), .Out3(out3),
    .Out4(out4), .Out5(out5), .Out6(out6), .Out7(out7),
    .Word(word), .SlotValid(slot_valid), .WordValid(word_valid),
    .WordAck(word_ack), .Overwrite(overwrite),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_out[i] = 8'h00;
      m_sv[i]  = 1'b0;
    end
    m_ptr  = 0;
    m_full = 1'b0;
    m_ow   = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit m,
                            input logic [2:0] s, input bit c, input bit a);
    int t;
    int filled;
    m_ow = 1'b0;
    if (c) begin
      for (int i = 0; i < 8; i++) m_sv[i] = 1'b0;
      m_ptr  = 0;
      m_full = 1'b0;
    end else if (m_full) begin
      if (a) begin
        for (int i = 0; i < 8; i++) m_sv[i] = 1'b0;
        m_ptr  = 0;
        m_full = 1'b0;
      end
    end else if (v) begin
      t = m ? m_ptr : int'(s);
      m_ow     = m_sv[t];
      m_out[t] = d;
      m_sv[t]  = 1'b1;
      if (m) m_ptr = (m_ptr + 1) % 8;
      filled = 0;
      for (int i = 0; i < 8; i++) filled += int'(m_sv[i]);
      m_full = (filled == 8);
    end
  endtask

  task automatic check_all();
    logic [63:0] w;
    logic [7:0]  svb;
    for (int i = 0; i < 8; i++) begin
      w[i*8 +: 8] = m_out[i];
      svb[i]      = m_sv[i];
    end
    chk("Out0", 64'(out0), 64'(m_out[0]));
    chk("Out1", 64'(out1), 64'(m_out[1]));
    chk("Out2", 64'(out2), 64'(m_out[2]));
    chk("Out3", 64'(out3), 64'(m_out[3]));
    chk("Out4", 64'(out4), 64'(m_out[4]));
    chk("Out5", 64'(out5), 64'(m_out[5]));
    chk("Out6", 64'(out6), 64'(m_out[6]));
    chk("Out7", 64'(out7), 64'(m_out[7]));
    chk("Word", word, w);
    chk("SlotValid", 64'(slot_valid), 64'(svb));
    chk("WordValid", 64'(word_valid), 64'(m_full));
    chk("InReady", 64'(in_ready), 64'(!m_full));
    chk("Overwrite", 64'(overwrite), 64'(m_ow));
    chk("state", 64'(dbg_state), 64'(m_full));
    chk("Ptr", 64'(dbg_ptr), 64'(m_ptr));
  endtask

  // Inputs are driven 1 time unit after an edge, sampled at the next edge,
  // and outputs are checked 1 time unit after that edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit m,
                       input logic [2:0] s, input bit c, input bit a);
    in_valid = v; in_d = d; mode = m; sel = s; clear = c; word_ack = a;
    @(posedge clk);
    model_edge(v, d, m, s, c, a);
    #1;
    check_all();
    in_valid = 1'b0; clear = 1'b0; word_ack = 1'b0;
  endtask

  task automatic async_reset_check();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; in_d = 8'h00; in_valid = 1'b0; sel = 3'd0; mode = 1'b0;
    clear = 1'b0; word_ack = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // sequential fill of a full word, then a refused ninth item and an ack
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b1, 3'd0, 1'b0, 1'b0);
    chk("seq_word", word, 64'h1716151413121110);
    chk("seq_full", 64'(word_valid), 64'd1);
    cycle(1'b1, 8'hAA, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("ninth_dropped", word, 64'h1716151413121110);
    cycle(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1);
    chk("ack_sv", 64'(slot_valid), 64'd0);
    chk("ack_out_kept", 64'(out7), 64'h17);

    // addressed fill in scrambled order
    begin
      logic [2:0] order [8];
      order = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
      for (int i = 0; i < 8; i++) begin
        cycle(1'b1, 8'(8'h40 + order[i]), 1'b0, order[i], 1'b0, 1'b0);
        chk("addr_ow", 64'(overwrite), 64'd0);
      end
    end
    chk("addr_word", word, 64'h4746454443424140);
    cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);

    // overwrite of slot 2
    cycle(1'b1, 8'h11, 1'b0, 3'd2, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 3'd2, 1'b0, 1'b0);
    chk("ow_pulse", 64'(overwrite), 64'd1);
    chk("ow_out2", 64'(out2), 64'h22);
    chk("ow_sv", 64'(slot_valid), 64'h04);
    cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("ow_one_cycle", 64'(overwrite), 64'd0);
    cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);

    // clear drops the concurrent item
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b1, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("clr_sv", 64'(slot_valid), 64'd0);
    cycle(1'b1, 8'h5C, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("clr_next_out0", 64'(out0), 64'h5C);
    chk("clr_next_sv", 64'(slot_valid), 64'h01);
    cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);

    // mixed modes to FULL, then ack and clear together
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b0, 3'd6, 1'b0, 1'b0);
    cycle(1'b1, 8'h67, 1'b0, 3'd7, 1'b0, 1'b0);
    chk("mix_full", 64'(word_valid), 64'd1);
    cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1);
    chk("mix_collect", 64'(in_ready), 64'd1);

    // asynchronous reset mid-word and while FULL
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b1, 3'd0, 1'b0, 1'b0);
    chk("pre_rst_ptr", 64'(dbg_ptr), 64'd3);
    async_reset_check();
    cycle(1'b1, 8'h5A, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("rst_first_out0", 64'(out0), 64'h5A);
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1, 3'd0, 1'b0, 1'b0);
    chk("pre_rst_full", 64'(word_valid), 64'd1);
    async_reset_check();
    cycle(1'b1, 8'hA5, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("rst2_first_out0", 64'(out0), 64'hA5);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_demux8.md
# byte_demux8

Byte demultiplexer/assembler: the receive-side counterpart of the 8-to-1 byte mux. It accepts a stream of WIDTH-bit items over a valid/ready handshake and stores each item in one of eight output slots. The slot is chosen by an explicit selector or by an internal auto-incrementing pointer. Once all eight slots hold fresh data, it presents the assembled word and holds it until acknowledged. It sits between byte-serial sources and the 64-bit datapath registers.

## Interface
- WIDTH, 8, bit width of each item and each slot.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- In  input  WIDTH  incoming item.
- InValid  input  1  In is valid this cycle.
- InReady  output  1  block can accept an item this cycle.
- Sel  input  3  target slot when Mode=0.
- Mode  input  1  0 = addressed write to Sel; 1 = sequential write to internal pointer Ptr.
- Clear  input  1  synchronous discard of the partial word.
- Out0..Out7  output  WIDTH each  slot registers.
- Word  output  8*WIDTH  {Out7,...,Out0}.
- SlotValid  output  8  bit i set when slot i has been written since the last ack/clear.
- WordValid  output  1  all eight slots are filled; word is stable.
- WordAck  input  1  consumer has taken Word.
- Overwrite  output  1  one-cycle pulse: an accepted write targeted an already-filled slot.

## Operation
- The state machine has two states: COLLECT and FULL. WordValid = (state==FULL) and InReady = (state==COLLECT), both registered-state decodes.
- An item is accepted when InValid && InReady && !Clear, evaluated at the rising edge.
- Target slot T = Sel when Mode=0, otherwise Ptr. Mode is sampled per item, and mixing modes is legal.
- On an accepted item:
  - OutT <= In and SlotValid[T] <= 1.
  - If Mode=1, Ptr <= Ptr+1 mod 8 (7 wraps to 0). Ptr is unchanged in Mode=0.
  - Overwrite pulses for one cycle if SlotValid[T] was already 1. The data is replaced and SlotValid is unchanged.
- COLLECT -> FULL at the edge where an accepted write makes SlotValid == 8'hFF.
- In FULL, In/InValid are ignored (InReady=0), and Out*/Word are held.
- FULL -> COLLECT at the edge where WordAck=1. At that edge SlotValid <= 0 and Ptr <= 0; Out0..Out7 keep their values.
- WordAck in COLLECT is ignored.
- Clear=1 (either state) at an edge:
  - SlotValid <= 0, Ptr <= 0, state <= COLLECT.
  - Any item presented that cycle is dropped, and Overwrite stays 0.
  - Clear has priority over both write and WordAck.
- Reset: Out0..Out7=0, SlotValid=0, Ptr=0, state=COLLECT, WordValid=0, Overwrite=0, InReady=1. No item is accepted while reset is high.

## Timing
- Write latency is 1 edge. An item accepted at edge E appears on OutT and SlotValid[T] immediately after E.
- WordValid rises immediately after the edge accepting the final missing slot. InReady falls in the same cycle. There is no bubble beyond that edge.
- After WordAck is sampled at edge A, WordValid=0 and InReady=1 following A, so a new item can be accepted at A+1.
- Throughput is one item per cycle in COLLECT. A full word needs at least 8 accepts followed by an ack cycle, giving a sustained rate of 8 items per 9 cycles with immediate ack.
- Overwrite is registered: it is high for exactly the cycle after the offending accept edge.
- Reset asserted mid-word or in FULL immediately forces the reset values (asynchronous). Deassertion takes effect at the next rising edge.

## Test plan
- Reset, then Mode=1, InValid=1 with In=8'h10..8'h17 on 8 consecutive cycles -> Out0..Out7=10..17, Word=64'h1716151413121110. WordValid rises after the 8th edge and InReady=0. A 9th item 8'hAA is not accepted. WordAck for 1 cycle -> SlotValid=0, Ptr=0, Out* unchanged.
- Mode=0, writes in order Sel=7,3,0,5,1,6,2,4 with In=Sel+8'h40 -> each OutN=8'h4N. WordValid asserts only after Sel=4 is written. Overwrite is never asserted.
- Mode=0, write Sel=2 In=8'h11 then Sel=2 In=8'h22 -> Out2=8'h22, SlotValid=8'h04, Overwrite high for exactly one cycle after the second write.
- Mode=1, 5 items, then Clear together with InValid=1 In=8'hFF -> item dropped, SlotValid=0. The next item lands in Out0.
- Mode=1, 6 items, then 2 items with Mode=0 Sel=6,7 -> FULL. WordAck and Clear asserted together -> COLLECT, Ptr=0, SlotValid=0.
- Assert reset asynchronously mid-word (Ptr=3) and while in FULL -> all outputs return to reset values before the next clock edge. The first item after reset release lands in Out0 (Mode=1).
